tcp_rx_msg_framer: RTL and testbench
====================================

# tcp_rx_msg_framer

Sits directly downstream of the TCP wrapper's application-side receive outputs, between the 88-bit notification stream and the 512-bit RX data stream on one side and the application on the other. For each notification it does three things: emits a compact message descriptor, forwards exactly the notified number of payload bytes, and regenerates `last` on the final beat of that message. Zero-length notifications, such as connection-close events, produce a descriptor only.

## Interface
- `DATA_W`, default 512: RX data width in bits; `KEEP_W = DATA_W/8`.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_meta_valid` / `s_meta_ready`  in / out  1 / 1  notification handshake.
- `s_meta_data`  in  88  notification: [15:0] session, [31:16] length in bytes, [63:32] IP, [79:64] port, [80] closed.
- `s_data_valid` / `s_data_ready`  in / out  1 / 1  RX payload handshake.
- `s_data_data` / `s_data_keep` / `s_data_last`  in  DATA_W / KEEP_W / 1  RX payload.
- `m_desc_valid` / `m_desc_ready`  out / in  1 / 1  descriptor handshake.
- `m_desc_data`  out  48  descriptor: [15:0] session, [31:16] length, [32] closed, [47:33] zero.
- `m_data_valid` / `m_data_ready`  out / in  1 / 1  framed payload handshake.
- `m_data_data` / `m_data_keep` / `m_data_last`  out  DATA_W / KEEP_W / 1  framed payload.
- `status_reg`  out  4×32  statistics (see Configuration).

## Operation
- FSM states: IDLE, DESC, DATA.
- **IDLE**
  - `s_meta_ready=1`.
  - On a handshake: latch session, length and closed into registers; load `remaining` (16 b) with length; go to DESC.
- **DESC**
  - `m_desc_valid=1` with the latched fields.
  - On `m_desc_ready`: if length==0, go to IDLE; otherwise go to DATA.
- **DATA**
  - Combinational pass-through: `m_data_valid = s_data_valid`, `s_data_ready = m_data_ready`, data and keep unchanged.
  - `m_data_last = (remaining <= KEEP_W)`. Upstream `s_data_last` is not forwarded.
  - On each output handshake: `remaining <= remaining - KEEP_W`, saturating at 0.
  - On a handshake with `m_data_last=1`: go to IDLE.
- `s_data_ready=0` and `m_data_valid=0` outside DATA; no payload is ever consumed without an owning notification.
- Keep on the final beat is passed through unmodified. Upstream guarantees it matches `length mod KEEP_W`; the block does not check it.
- Mismatch: an upstream `s_data_last=1` on a beat where `m_data_last=0`, or `m_data_last=1` on a beat where `s_data_last=0`, increments the mismatch counter (when enabled). Framing always follows the notified length.
- All arithmetic is unsigned; `remaining` never underflows.

## Timing
- Reset values:
  - state=IDLE, `remaining`=0, latched fields=0.
  - `s_meta_ready=1`; `m_desc_valid=0`, `m_data_valid=0`, `s_data_ready=0`, `m_data_last=0`.
  - `status_reg`=0.
- Latency:
  - notification accept → `m_desc_valid`: 1 cycle.
  - descriptor accept → first data beat eligible: next cycle.
  - data path: 0 cycles (combinational).
- Throughput:
  - One bubble cycle per message (the IDLE cycle), plus the DESC cycle.
  - Within a message, one beat per cycle.
- Handshake rules:
  - Valid outputs never drop and descriptor data never changes while waiting for ready.
  - Ready never depends on own valid.
- length == 1…64 → exactly one beat, `last=1`. length == 65 → two beats.
- length == 0 → no data beats; the `closed` bit is carried in the descriptor.
- Reset asserted mid-message: all state is cleared immediately. Remaining payload of the interrupted message is not discarded by this block; upstream is reset together with it.

## Configuration
- `RX_FRAMER_STATS_EN` defined: `status_reg` carries saturating 32-bit counters.
  - [0] descriptors accepted.
  - [1] payload bytes forwarded, computed as the sum of non-zero lengths at descriptor accept.
  - [2] last-mismatch events.
  - [3] cycles in DATA with `s_data_valid=0`, i.e. upstream starvation.
- Not defined: `status_reg` tied to 0; no counter logic is synthesised.

## Test plan
- Notification {session=5, length=128}, two full-keep beats, sinks always ready → descriptor 0x0080_0005 one cycle after accept; two output beats, `last` only on the second; back in IDLE.
- length=100, beats with keep all-ones then keep=0x0000_000F_FFFF_FFFF → two beats, `last` on the second with keep unchanged; `remaining` saturates to 0.
- length=0 with closed=1 → descriptor bit 32 set; `s_data_ready` stays 0; an offered data beat stays unconsumed until the next non-zero notification.
- Back-to-back notifications of length 64 and 192, `m_data_ready` toggling every cycle → 1 + 3 beats in order, `last` on beats 1 and 4; no beat lost or duplicated under backpressure.
- Upstream asserts `s_data_last` on beat 1 of a 3-beat (length 150) message → output `last` only on beat 3; with `RX_FRAMER_STATS_EN`, `status_reg[2]=1` and `status_reg[1]=150`.
- Assert `rst` during beat 2 of 4 → outputs return to reset values asynchronously; next notification is framed correctly from IDLE.

Source files
------------

// File: rtl/tcp_rx_msg_framer_if.sv
// tcp_rx_msg_framer_if: handshake bundle around the RX message framer.
// Carries the notification stream, the raw RX payload stream, the outgoing
// descriptor stream and the framed payload stream. The slave modport is the
// framer's view. The master modport is the view of the logic that surrounds it.
interface tcp_rx_msg_framer_if #(
   parameter int DATA_W = 512
);
   localparam int KEEP_W = DATA_W / 8;

   logic                s_meta_valid;
   logic                s_meta_ready;
   logic [87:0]         s_meta_data;

   logic                s_data_valid;
   logic                s_data_ready;
   logic [DATA_W-1:0]   s_data_data;
   logic [KEEP_W-1:0]   s_data_keep;
   logic                s_data_last;

   logic                m_desc_valid;
   logic                m_desc_ready;
   logic [47:0]         m_desc_data;

   logic                m_data_valid;
   logic                m_data_ready;
   logic [DATA_W-1:0]   m_data_data;
   logic [KEEP_W-1:0]   m_data_keep;
   logic                m_data_last;

   modport slave (
      input  s_meta_valid, s_meta_data,
      output s_meta_ready,
      input  s_data_valid, s_data_data, s_data_keep, s_data_last,
      output s_data_ready,
      output m_desc_valid, m_desc_data,
      input  m_desc_ready,
      output m_data_valid, m_data_data, m_data_keep, m_data_last,
      input  m_data_ready
   );

   modport master (
      output s_meta_valid, s_meta_data,
      input  s_meta_ready,
      output s_data_valid, s_data_data, s_data_keep, s_data_last,
      input  s_data_ready,
      input  m_desc_valid, m_desc_data,
      output m_desc_ready,
      input  m_data_valid, m_data_data, m_data_keep, m_data_last,
      output m_data_ready
   );
endinterface

// File: rtl/tcp_rx_msg_framer.sv
// tcp_rx_msg_framer: turns each TCP RX notification into a 48-bit descriptor.
// It then forwards exactly the notified number of payload bytes and
// regenerates last on the final beat of each message.
// Optional macro RX_FRAMER_STATS_EN: enables the four saturating statistics
// counters on status_reg. When it is not defined, status_reg is tied to zero.
module tcp_rx_msg_framer #(
   parameter int DATA_W = 512
) (
   input  logic                 clk,
   input  logic                 rst,
   tcp_rx_msg_framer_if.slave   bus,
   output logic [3:0][31:0]     status_reg
);
   localparam int          KEEP_W     = DATA_W / 8;
   localparam logic [15:0] KEEP_BYTES = 16'(KEEP_W);

   typedef enum logic [1:0] {IDLE, DESC, DATA} state_t;

   state_t      state, state_nxt;
   logic [15:0] session_q, length_q, remaining;
   logic        closed_q;
   logic        meta_hs, desc_hs, data_hs;

   // remaining bytes never go below zero, even when the final beat is short
   function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? (a - b) : 16'd0;
   endfunction

   // IP, port and reserved notification bits are not needed downstream;
   // upstream last is only consulted by the statistics
   logic unused_bits;
   assign unused_bits = ^{bus.s_meta_data[87:81], bus.s_meta_data[79:32], bus.s_data_last};

   assign meta_hs = bus.s_meta_valid && bus.s_meta_ready;
   assign desc_hs = bus.m_desc_valid && bus.m_desc_ready;
   assign data_hs = bus.m_data_valid && bus.m_data_ready;

   assign bus.m_desc_data = {15'd0, closed_q, length_q, session_q};
   assign bus.m_data_data = bus.s_data_data;
   assign bus.m_data_keep = bus.s_data_keep;

   // next-state and handshake outputs; the payload path is live only in DATA
   always_comb begin
      state_nxt        = state;
      bus.s_meta_ready = 1'b0;
      bus.m_desc_valid = 1'b0;
      bus.m_data_valid = 1'b0;
      bus.s_data_ready = 1'b0;
      bus.m_data_last  = 1'b0;
      case (state)
         IDLE: begin
            bus.s_meta_ready = 1'b1;
            if (bus.s_meta_valid) state_nxt = DESC;
         end
         DESC: begin
            bus.m_desc_valid = 1'b1;
            if (bus.m_desc_ready) state_nxt = (length_q == 16'd0) ? IDLE : DATA;
         end
         DATA: begin
            bus.m_data_valid = bus.s_data_valid;
            bus.s_data_ready = bus.m_data_ready;
            bus.m_data_last  = (remaining <= KEEP_BYTES);
            if (bus.s_data_valid && bus.m_data_ready && (remaining <= KEEP_BYTES))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state register, latched notification fields and the byte countdown
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         session_q <= '0;
         length_q  <= '0;
         closed_q  <= 1'b0;
         remaining <= '0;
      end else begin
         state <= state_nxt;
         if (meta_hs) begin
            session_q <= bus.s_meta_data[15:0];
            length_q  <= bus.s_meta_data[31:16];
            closed_q  <= bus.s_meta_data[80];
            remaining <= bus.s_meta_data[31:16];
         end else if (data_hs) begin
            remaining <= sat_sub(remaining, KEEP_BYTES);
         end
      end
   end

`ifdef RX_FRAMER_STATS_EN
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[32] ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   logic [31:0] cnt_desc, cnt_bytes, cnt_mis, cnt_starve;

   // statistics: descriptors, notified bytes, last disagreements, starvation cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_desc   <= '0;
         cnt_bytes  <= '0;
         cnt_mis    <= '0;
         cnt_starve <= '0;
      end else begin
         if (desc_hs)
            cnt_desc <= sat_add(cnt_desc, 32'd1);
         if (desc_hs && (length_q != 16'd0))
            cnt_bytes <= sat_add(cnt_bytes, {16'd0, length_q});
         if (data_hs && (bus.s_data_last != bus.m_data_last))
            cnt_mis <= sat_add(cnt_mis, 32'd1);
         if ((state == DATA) && !bus.s_data_valid)
            cnt_starve <= sat_add(cnt_starve, 32'd1);
      end
   end

   assign status_reg = {cnt_starve, cnt_mis, cnt_bytes, cnt_desc};
`else
   assign status_reg = '0;
`endif
endmodule

// File: tb/tb_tcp_rx_msg_framer.sv
// tb_tcp_rx_msg_framer: directed bench for tcp_rx_msg_framer at DATA_W=512.
// Inputs change 1 time unit after the rising edge. Outputs are sampled 1 time
// unit after that, so every sample is taken well away from the active edge.
module tb_tcp_rx_msg_framer;
   logic            clk;
   logic            rst;
   logic [3:0][31:0] status_reg;
   int              passes = 0;
   int              total  = 0;

   tcp_rx_msg_framer_if #(.DATA_W(512)) bus ();

   tcp_rx_msg_framer #(.DATA_W(512)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .status_reg (status_reg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [511:0] pat(input int n);
      return {16{32'(n) ^ 32'hA5A5_0000}};
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // offer one notification, then confirm the descriptor appears one cycle later
   task automatic send_meta(input string tag, input logic [15:0] ses, input logic [15:0] len,
                            input logic closed);
      bus.s_meta_valid = 1'b1;
      bus.s_meta_data  = {7'd0, closed, 16'h1234, 32'hC0A8_0001, len, ses};
      #1;
      chk1({tag, ".meta_ready"}, bus.s_meta_ready, 1'b1);
      tick();
      bus.s_meta_valid = 1'b0;
      #1;
      chk1({tag, ".desc_valid"}, bus.m_desc_valid, 1'b1);
      chk1({tag, ".meta_ready_busy"}, bus.s_meta_ready, 1'b0);
   endtask

   task automatic take_desc(input string tag, input logic [47:0] exp);
      bus.m_desc_ready = 1'b1;
      #1;
      chkw({tag, ".desc_data"}, 512'(bus.m_desc_data), 512'(exp));
      tick();
      bus.m_desc_ready = 1'b0;
   endtask

   task automatic beat(input string tag, input int n, input logic [63:0] keep,
                       input logic slast, input logic exp_last);
      bus.s_data_valid = 1'b1;
      bus.s_data_data  = pat(n);
      bus.s_data_keep  = keep;
      bus.s_data_last  = slast;
      bus.m_data_ready = 1'b1;
      #1;
      chk1({tag, ".valid"}, bus.m_data_valid, 1'b1);
      chk1({tag, ".s_ready"}, bus.s_data_ready, 1'b1);
      chk1({tag, ".last"}, bus.m_data_last, exp_last);
      chkw({tag, ".data"}, bus.m_data_data, pat(n));
      chkw({tag, ".keep"}, 512'(bus.m_data_keep), 512'(keep));
      tick();
      bus.s_data_valid = 1'b0;
      bus.s_data_last  = 1'b0;
   endtask

   // one stalled cycle, then the accepting cycle
   task automatic beat_bp(input string tag, input int n, input logic exp_last);
      bus.s_data_valid = 1'b1;
      bus.s_data_data  = pat(n);
      bus.s_data_keep  = '1;
      bus.s_data_last  = 1'b0;
      bus.m_data_ready = 1'b0;
      #1;
      chk1({tag, ".stall_valid"}, bus.m_data_valid, 1'b1);
      chk1({tag, ".stall_s_ready"}, bus.s_data_ready, 1'b0);
      tick();
      bus.m_data_ready = 1'b1;
      #1;
      chk1({tag, ".valid"}, bus.m_data_valid, 1'b1);
      chk1({tag, ".last"}, bus.m_data_last, exp_last);
      chkw({tag, ".data"}, bus.m_data_data, pat(n));
      tick();
      bus.s_data_valid = 1'b0;
      bus.m_data_ready = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      #1;
      chk1({tag, ".meta_ready"}, bus.s_meta_ready, 1'b1);
      chk1({tag, ".s_ready"}, bus.s_data_ready, 1'b0);
      chk1({tag, ".m_valid"}, bus.m_data_valid, 1'b0);
      chk1({tag, ".desc_valid"}, bus.m_desc_valid, 1'b0);
   endtask

   initial begin
      bus.s_meta_valid = 1'b0;
      bus.s_meta_data  = '0;
      bus.s_data_valid = 1'b0;
      bus.s_data_data  = '0;
      bus.s_data_keep  = '0;
      bus.s_data_last  = 1'b0;
      bus.m_desc_ready = 1'b0;
      bus.m_data_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();

      // reset values
      chk_idle("rst");
      chk1("rst.last", bus.m_data_last, 1'b0);
      chkw("rst.status", 512'(status_reg), 512'd0);
      chkw("rst.desc_data", 512'(bus.m_desc_data), 512'd0);
      rst = 1'b0;
      tick();

      // session 5, 128 bytes: descriptor held under backpressure, then two beats
      send_meta("t1", 16'd5, 16'd128, 1'b0);
      chkw("t1.desc_hold0", 512'(bus.m_desc_data), 512'(48'h0000_0080_0005));
      tick();
      chk1("t1.desc_hold_valid", bus.m_desc_valid, 1'b1);
      chkw("t1.desc_hold1", 512'(bus.m_desc_data), 512'(48'h0000_0080_0005));
      take_desc("t1", 48'h0000_0080_0005);
      beat("t1.b1", 11, '1, 1'b0, 1'b0);
      beat("t1.b2", 12, '1, 1'b1, 1'b1);
      chk_idle("t1.end");

      // session 7, 100 bytes: short final beat keeps its keep pattern
      send_meta("t2", 16'd7, 16'd100, 1'b0);
      take_desc("t2", 48'h0000_0064_0007);
      beat("t2.b1", 21, '1, 1'b0, 1'b0);
      beat("t2.b2", 22, 64'h0000_000F_FFFF_FFFF, 1'b1, 1'b1);
      chk_idle("t2.end");

      // zero-length close: descriptor only, offered payload stays unconsumed
      send_meta("t3", 16'd9, 16'd0, 1'b1);
      take_desc("t3", 48'h0001_0000_0009);
      bus.s_data_valid = 1'b1;
      bus.s_data_data  = pat(31);
      bus.s_data_keep  = '1;
      bus.m_data_ready = 1'b1;
      chk_idle("t3.idle");
      tick();
      chk_idle("t3.idle2");
      send_meta("t3n", 16'd3, 16'd64, 1'b0);
      chk1("t3n.desc_s_ready", bus.s_data_ready, 1'b0);
      take_desc("t3n", 48'h0000_0040_0003);
      beat("t3n.b1", 31, '1, 1'b1, 1'b1);
      chk_idle("t3n.end");

      // back-to-back 64 and 192 bytes with sink stalling every other cycle
      send_meta("t4a", 16'd1, 16'd64, 1'b0);
      take_desc("t4a", 48'h0000_0040_0001);
      beat_bp("t4.b1", 41, 1'b1);
      send_meta("t4b", 16'd2, 16'd192, 1'b0);
      take_desc("t4b", 48'h0000_00C0_0002);
      beat_bp("t4.b2", 42, 1'b0);
      beat_bp("t4.b3", 43, 1'b0);
      beat_bp("t4.b4", 44, 1'b1);
      chk_idle("t4.end");

      // fresh counters, then 150 bytes with an early upstream last
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      send_meta("t5", 16'd4, 16'd150, 1'b0);
      take_desc("t5", 48'h0000_0096_0004);
      beat("t5.b1", 51, '1, 1'b1, 1'b0);
      beat("t5.b2", 52, '1, 1'b0, 1'b0);
      beat("t5.b3", 53, 64'h0000_0000_003F_FFFF, 1'b1, 1'b1);
      chk_idle("t5.end");
`ifdef RX_FRAMER_STATS_EN
      chkw("t5.stat_desc", 512'(status_reg[0]), 512'd1);
      chkw("t5.stat_bytes", 512'(status_reg[1]), 512'd150);
      chkw("t5.stat_mis", 512'(status_reg[2]), 512'd1);
      chkw("t5.stat_starve", 512'(status_reg[3]), 512'd0);
`else
      chkw("t5.status_off", 512'(status_reg), 512'd0);
`endif

      // reset asserted during beat 2 of a 4-beat message
      send_meta("t6", 16'd6, 16'd256, 1'b0);
      take_desc("t6", 48'h0000_0100_0006);
      beat("t6.b1", 61, '1, 1'b0, 1'b0);
      bus.s_data_valid = 1'b1;
      bus.s_data_data  = pat(62);
      bus.m_data_ready = 1'b1;
      #1;
      chk1("t6.b2_valid", bus.m_data_valid, 1'b1);
      rst = 1'b1;
      chk_idle("t6.async");
      chkw("t6.async_status", 512'(status_reg), 512'd0);
      chkw("t6.async_desc", 512'(bus.m_desc_data), 512'd0);
      rst = 1'b0;
      bus.s_data_valid = 1'b0;
      tick();
      send_meta("t6n", 16'd8, 16'd65, 1'b0);
      take_desc("t6n", 48'h0000_0041_0008);
      beat("t6n.b1", 63, '1, 1'b0, 1'b0);
      beat("t6n.b2", 64, 64'h1, 1'b1, 1'b1);
      chk_idle("t6n.end");
`ifdef RX_FRAMER_STATS_EN
      chkw("t6n.stat_bytes", 512'(status_reg[1]), 512'd65);
      chkw("t6n.stat_mis", 512'(status_reg[2]), 512'd0);
`else
      chkw("t6n.status_off", 512'(status_reg), 512'd0);
`endif

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
